pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module      : pipe_stage_skid
// Description : Two-entry skid-buffered pipeline stage; control fields read as
//               zero (NOP) on a bubble. Optional stall/bubble counters are
//               enabled by defining PIPE_STAGE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles
`endif
);

    // State encoding doubles as the entry count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_fire;
    logic              out_fire;

    assign in_ready  = !reset && (state_q != ST_FULL);
    assign out_valid = !reset && (state_q != ST_EMPTY);
    assign out_data  = reset ? '0 : main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign occupancy = reset ? ST_EMPTY : state_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end else if (in_fire) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                    state_d     = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops everything, including a same-cycle accepted input, and
        // leaves the payload registers untouched so out_data keeps its value.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
            skid_data_d = skid_data_q;
            skid_ctrl_d = skid_ctrl_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_q,  stall_d;
    logic [31:0] bubble_q, bubble_d;

    // Saturating counters; flush deliberately leaves them alone.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        if (!out_valid && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid: directed vector table,
//               FIFO scoreboard and random traffic; stats counters when
//               PIPE_STAGE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    localparam int DW = 160;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]   stall_cycles, bubble_cycles;
`endif

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .occupancy     (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    typedef struct {
        logic       rst, fl, iv, ordy;
        logic [7:0] v;
        logic       e_rdy, e_ov;
        logic [1:0] e_occ;
        logic [7:0] e_v;
    } vec_t;

    ent_t sb[$];
    vec_t tbl[28];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [DW-1:0] mk_d(input logic [7:0] v);
        return {(DW/8){v}};
    endfunction

    function automatic logic [CW-1:0] mk_c(input logic [7:0] v);
        return {v ^ 8'h5A, v};
    endfunction

    function automatic vec_t vec(input logic rst, fl, iv, ordy, input logic [7:0] v,
                                 input logic e_rdy, e_ov, input logic [1:0] e_occ,
                                 input logic [7:0] e_v);
        vec_t t;
        t.rst = rst; t.fl = fl; t.iv = iv; t.ordy = ordy; t.v = v;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_occ = e_occ; t.e_v = e_v;
        return t;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: scoreboard checks at the falling edge, then advance past the rising edge.
    task automatic cycle();
        logic       er, ev;
        logic [1:0] eo;
        @(negedge CLK);
        er = !reset && (sb.size() < 2);
        ev = !reset && (sb.size() > 0);
        eo = reset ? 2'd0 : 2'(sb.size());
        check("sb_in_ready", DW'(in_ready), DW'(er));
        check("sb_out_valid", DW'(out_valid), DW'(ev));
        check("sb_occupancy", DW'(occupancy), DW'(eo));
        if (!ev) check("sb_bubble_ctrl", DW'(out_ctrl), '0);
        if (ev && out_ready) begin
            check("sb_out_data", out_data, sb[0].d);
            check("sb_out_ctrl", DW'(out_ctrl), DW'(sb[0].c));
            void'(sb.pop_front());
        end
        if (reset || flush) sb.delete();
        else if (in_valid && er) sb.push_back('{d: in_data, c: in_ctrl});
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rst, fl, iv, ordy, input logic [7:0] v);
        reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
        in_data = mk_d(v); in_ctrl = mk_c(v);
    endtask

    initial begin
        //                rst fl iv or  v      rdy ov occ out
        tbl[0]  = vec(1, 0, 1, 0, 8'h09, 0, 0, 0, 8'h00);
        tbl[1]  = vec(1, 0, 1, 0, 8'h09, 0, 0, 0, 8'h00);
        tbl[2]  = vec(0, 0, 0, 1, 8'h00, 1, 0, 0, 8'h00);
        tbl[3]  = vec(0, 0, 1, 1, 8'h01, 1, 0, 0, 8'h00);
        tbl[4]  = vec(0, 0, 1, 1, 8'h02, 1, 1, 1, 8'h01);
        tbl[5]  = vec(0, 0, 1, 1, 8'h03, 1, 1, 1, 8'h02);
        tbl[6]  = vec(0, 0, 1, 1, 8'h04, 1, 1, 1, 8'h03);
        tbl[7]  = vec(0, 0, 0, 1, 8'h00, 1, 1, 1, 8'h04);
        tbl[8]  = vec(0, 0, 1, 0, 8'h0A, 1, 0, 0, 8'h04);
        tbl[9]  = vec(0, 0, 1, 0, 8'h0B, 1, 1, 1, 8'h0A);
        tbl[10] = vec(0, 0, 1, 0, 8'h0C, 0, 1, 2, 8'h0A);
        tbl[11] = vec(0, 0, 1, 1, 8'h0C, 0, 1, 2, 8'h0A);
        tbl[12] = vec(0, 0, 1, 1, 8'h0C, 1, 1, 1, 8'h0B);
        tbl[13] = vec(0, 0, 0, 1, 8'h00, 1, 1, 1, 8'h0C);
        tbl[14] = vec(0, 0, 1, 0, 8'h1A, 1, 0, 0, 8'h0C);
        tbl[15] = vec(0, 0, 1, 0, 8'h1B, 1, 1, 1, 8'h1A);
        tbl[16] = vec(0, 1, 1, 0, 8'h0D, 0, 1, 2, 8'h1A);
        tbl[17] = vec(0, 0, 0, 1, 8'h00, 1, 0, 0, 8'h1A);
        tbl[18] = vec(0, 0, 0, 1, 8'h00, 1, 0, 0, 8'h1A);
        tbl[19] = vec(0, 0, 1, 0, 8'h2A, 1, 0, 0, 8'h1A);
        tbl[20] = vec(0, 0, 1, 1, 8'h2B, 1, 1, 1, 8'h2A);
        tbl[21] = vec(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h2B);
        tbl[22] = vec(0, 0, 0, 1, 8'h00, 1, 1, 1, 8'h2B);
        tbl[23] = vec(0, 0, 0, 1, 8'h00, 1, 0, 0, 8'h2B);
        tbl[24] = vec(0, 0, 1, 0, 8'h3A, 1, 0, 0, 8'h2B);
        tbl[25] = vec(0, 0, 1, 0, 8'h3B, 1, 1, 1, 8'h3A);
        tbl[26] = vec(1, 1, 1, 0, 8'h3C, 0, 0, 0, 8'h00);
        tbl[27] = vec(0, 0, 0, 1, 8'h00, 1, 0, 0, 8'h00);

        drive(1, 0, 1, 0, 8'h09);
        @(posedge CLK);
        #1;

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].v);
            #1;
            check($sformatf("vec%0d_in_ready", i), DW'(in_ready), DW'(tbl[i].e_rdy));
            check($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(tbl[i].e_ov));
            check($sformatf("vec%0d_occupancy", i), DW'(occupancy), DW'(tbl[i].e_occ));
            check($sformatf("vec%0d_out_data", i), out_data, mk_d(tbl[i].e_v));
            check($sformatf("vec%0d_out_ctrl", i), DW'(out_ctrl),
                  tbl[i].e_ov ? DW'(mk_c(tbl[i].e_v)) : '0);
            cycle();
        end

        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            in_ctrl   = CW'($urandom());
            cycle();
        end

`ifdef PIPE_STAGE_STATS_EN
        drive(1, 0, 0, 0, 8'h00);
        cycle();
        drive(0, 0, 1, 0, 8'h55);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 8'h00);
            cycle();
        end
        drive(0, 1, 0, 0, 8'h00);
        cycle();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 8'h00);
            cycle();
        end
        #1;
        check("stall_cycles", DW'(stall_cycles), DW'(32'd5));
        check("bubble_cycles", DW'(bubble_cycles), DW'(32'd3));
`endif

        drive(0, 0, 0, 1, 8'h00);
        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
